fs_stage: RTL and testbench

Instruction-fetch (IF) stage of the five-stage in-order LoongArch pipeline. It sits between the pre-IF stage and the decode stage (ds). It accepts one PC plus its fetch-exception flags per issued instruction-SRAM request, waits for that request's `inst_sram_data_ok`, and buffers the returned instruction when ds stalls. On a flush or branch cancel it kills the in-flight entry and discards the SRAM responses that are still outstanding.

---
 rtl/fs_stage.sv | 137 +++++++++++++
 tb/tb_fs_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fs_stage.sv
// -----------------------------------------------------------------------------
// fs_stage -- instruction-fetch (IF) stage of the in-order LoongArch pipeline.
//
// Holds one fetch entry (pc + fetch-exception flags) between pre-IF and decode.
// The entry waits for its instruction-SRAM response. If decode stalls, the
// returned instruction is buffered. A flush or a taken-branch cancel kills the
// entry. Any SRAM responses still owed to killed entries are counted in
// drop_cnt_q and discarded as they arrive.
//
// Ports
//   clk, resetn          : clock, synchronous active-low reset
//   pfs_to_fs_valid/bus  : entry from pre-IF, bus = {exc_flgs, pc}
//   fs_allowin           : fs can accept an entry this cycle
//   inst_sram_data_ok    : one in-order SRAM response this cycle
//   inst_sram_rdata      : response data
//   ds_allowin           : decode accepts this cycle
//   fs_to_ds_valid/bus   : entry toward decode, bus = {exc_flgs, inst, pc}
//   flush                : exception / ertn / refetch kill
//   br_taken_cancel      : taken branch resolved in decode, kills the entry
//
// Handshake: a transfer happens on a cycle where the producer's valid and the
// consumer's allowin are both high. A valid producer holds its bus stable
// until that transfer happens, unless a kill removes the entry.
// -----------------------------------------------------------------------------
module fs_stage #(
    parameter int EXC_NUM = 15
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   pfs_to_fs_valid,
    input  logic [EXC_NUM+31:0]    pfs_to_fs_bus,
    output logic                   fs_allowin,
    input  logic                   inst_sram_data_ok,
    input  logic [31:0]            inst_sram_rdata,
    input  logic                   ds_allowin,
    output logic                   fs_to_ds_valid,
    output logic [EXC_NUM+63:0]    fs_to_ds_bus,
    input  logic                   flush,
    input  logic                   br_taken_cancel
);

    logic               fs_valid_q,       fs_valid_d;
    logic [31:0]        fs_pc_q,          fs_pc_d;
    logic [EXC_NUM-1:0] fs_exc_q,         fs_exc_d;
    logic               inst_buf_valid_q, inst_buf_valid_d;
    logic [31:0]        inst_buf_q,       inst_buf_d;
    logic [1:0]         drop_cnt_q,       drop_cnt_d;

    logic        kill;
    logic        take_data;
    logic        fs_ready_go;
    logic        load;
    logic        leave;
    logic        pending;
    logic        drop_inc;
    logic        drop_dec;
    logic [31:0] inst_raw;
    logic [31:0] inst;

    assign kill        = flush | br_taken_cancel;
    // A response only belongs to the current entry once no stale responses remain.
    assign take_data   = inst_sram_data_ok & (drop_cnt_q == 2'd0);
    assign fs_ready_go = inst_buf_valid_q | take_data;
    assign fs_allowin  = ~fs_valid_q | (fs_ready_go & ds_allowin);
    assign fs_to_ds_valid = fs_valid_q & fs_ready_go & ~kill;

    assign load  = pfs_to_fs_valid & fs_allowin & ~kill;
    assign leave = fs_valid_q & fs_ready_go & ds_allowin;

    // The entry still owns a response that has not come back yet.
    assign pending  = fs_valid_q & ~inst_buf_valid_q & ~take_data;
    assign drop_inc = kill & pending;
    assign drop_dec = inst_sram_data_ok & (drop_cnt_q != 2'd0);

    // Exception-flagged entries carry a zero instruction. Their response is
    // still consumed, because pre-IF issued the request regardless of the flags.
    assign inst_raw = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
    assign inst     = (|fs_exc_q) ? 32'h0 : inst_raw;

    assign fs_to_ds_bus = {fs_exc_q, inst, fs_pc_q};

    always_comb begin
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        fs_exc_d         = fs_exc_q;
        inst_buf_valid_d = inst_buf_valid_q;
        inst_buf_d       = inst_buf_q;
        drop_cnt_d       = drop_cnt_q;

        // Kill wins over load and leave. Leave is checked after load, so a
        // simultaneous leave and load simply replaces the entry.
        if (kill) begin
            fs_valid_d       = 1'b0;
            inst_buf_valid_d = 1'b0;
        end else if (load) begin
            fs_valid_d       = 1'b1;
            fs_pc_d          = pfs_to_fs_bus[31:0];
            fs_exc_d         = pfs_to_fs_bus[EXC_NUM+31:32];
            inst_buf_valid_d = 1'b0;
        end else if (leave) begin
            fs_valid_d       = 1'b0;
            inst_buf_valid_d = 1'b0;
        end else if (take_data && fs_valid_q && !ds_allowin) begin
            inst_buf_d       = inst_sram_rdata;
            inst_buf_valid_d = 1'b1;
        end

        // Increment and decrement in the same cycle cancel out.
        // The count holds at 3 rather than wrapping.
        if (drop_inc && !drop_dec) begin
            if (drop_cnt_q != 2'd3) begin
                drop_cnt_d = drop_cnt_q + 2'd1;
            end
        end else if (drop_dec && !drop_inc) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= 32'h0;
            fs_exc_q         <= '0;
            inst_buf_valid_q <= 1'b0;
            inst_buf_q       <= 32'h0;
            drop_cnt_q       <= 2'd0;
        end else begin
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            fs_exc_q         <= fs_exc_d;
            inst_buf_valid_q <= inst_buf_valid_d;
            inst_buf_q       <= inst_buf_d;
            drop_cnt_q       <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_fs_stage.sv
// -----------------------------------------------------------------------------
// tb_fs_stage -- directed and random bench for fs_stage.
// Reference model: an in-order queue of outstanding request ids. A response
// belongs to the live entry only if it carries that entry's id. Any other
// response is stale, and the expected drop count is the number of stale ids.
// -----------------------------------------------------------------------------
module tb_fs_stage;

    localparam int EXC_NUM = 15;
    localparam int BW      = EXC_NUM + 64;
    localparam logic [EXC_NUM-1:0] ADEF_FLG = EXC_NUM'(1) << 8;

    logic               clk;
    logic               resetn;
    logic               pfs_to_fs_valid;
    logic [EXC_NUM+31:0] pfs_to_fs_bus;
    logic               fs_allowin;
    logic               inst_sram_data_ok;
    logic [31:0]        inst_sram_rdata;
    logic               ds_allowin;
    logic               fs_to_ds_valid;
    logic [BW-1:0]      fs_to_ds_bus;
    logic               flush;
    logic               br_taken_cancel;

    fs_stage #(.EXC_NUM(EXC_NUM)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .pfs_to_fs_valid   (pfs_to_fs_valid),
        .pfs_to_fs_bus     (pfs_to_fs_bus),
        .fs_allowin        (fs_allowin),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .flush             (flush),
        .br_taken_cancel   (br_taken_cancel)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int checks = 0;
    int errors = 0;
    int delivered = 0;

    // ---------------- reference model ----------------
    bit                 m_valid;
    bit                 m_have;
    logic [31:0]        m_pc;
    logic [31:0]        m_inst;
    logic [EXC_NUM-1:0] m_exc;
    int                 cur_id;
    int                 next_id;
    int                 out_q[$];

    logic               last_valid;
    logic               last_allowin;
    logic [BW-1:0]      last_bus;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit front_mine();
        return m_valid && !m_have && out_q.size() > 0 && out_q[0] == cur_id;
    endfunction

    function automatic bit m_ready(input logic dok);
        return m_have || (dok && front_mine());
    endfunction

    function automatic bit m_allowin(input logic dok, input logic dsa);
        return !m_valid || (m_ready(dok) && dsa);
    endfunction

    function automatic int m_orphans();
        return out_q.size() - ((m_valid && !m_have) ? 1 : 0);
    endfunction

    task automatic model_clear();
        m_valid = 0;
        m_have  = 0;
        m_pc    = '0;
        m_inst  = '0;
        m_exc   = '0;
        out_q.delete();
    endtask

    // One clock cycle: drive at negedge, compare comb outputs, advance model.
    task automatic step(input logic pv, input logic [31:0] pc, input logic [EXC_NUM-1:0] exc,
                        input logic dok, input logic [31:0] rd, input logic dsa,
                        input logic fl, input logic bc);
        logic          kill;
        logic          mine;
        logic          rdy;
        logic          exp_allow;
        logic          exp_valid;
        logic [31:0]   exp_inst;
        logic [BW-1:0] exp_bus;
        @(negedge clk);
        pfs_to_fs_valid   = pv;
        pfs_to_fs_bus     = {exc, pc};
        inst_sram_data_ok = dok;
        inst_sram_rdata   = rd;
        ds_allowin        = dsa;
        flush             = fl;
        br_taken_cancel   = bc;
        #1;
        kill      = fl | bc;
        mine      = dok && front_mine();
        rdy       = m_ready(dok);
        exp_allow = m_allowin(dok, dsa);
        exp_valid = m_valid && rdy && !kill;
        exp_inst  = (m_exc != '0) ? 32'h0 : (m_have ? m_inst : rd);
        exp_bus   = {m_exc, exp_inst, m_pc};
        last_valid   = fs_to_ds_valid;
        last_allowin = fs_allowin;
        last_bus     = fs_to_ds_bus;
        check("allowin", fs_allowin, exp_allow);
        check("valid", fs_to_ds_valid, exp_valid);
        if (exp_valid) check("bus", fs_to_ds_bus, exp_bus);
        check("unexpected_resp", dok && !dut.fs_valid_q && dut.drop_cnt_q == 2'd0, 0);
        if (exp_valid && dsa) delivered++;
        if (dok) void'(out_q.pop_front());
        if (mine && !kill) begin
            m_have = 1;
            m_inst = rd;
        end
        if (kill) begin
            m_valid = 0;
            m_have  = 0;
        end else if (m_valid && rdy && dsa) begin
            m_valid = 0;
            m_have  = 0;
        end
        if (pv && exp_allow && !kill) begin
            next_id++;
            cur_id = next_id;
            out_q.push_back(cur_id);
            m_valid = 1;
            m_have  = 0;
            m_pc    = pc;
            m_exc   = exc;
        end
        @(posedge clk);
        #1;
        check("drop_cnt", dut.drop_cnt_q, m_orphans());
        check("drop_sat", dut.drop_cnt_q == 2'd3, 0);
    endtask

    task automatic idle(input logic dsa);
        step(1'b0, 32'h0, '0, 1'b0, 32'h0, dsa, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn            = 1'b0;
        pfs_to_fs_valid   = 1'b0;
        pfs_to_fs_bus     = '0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        ds_allowin        = 1'b0;
        flush             = 1'b0;
        br_taken_cancel   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", fs_to_ds_valid, 0);
        check("rst_allowin", fs_allowin, 1);
        check("rst_bus", fs_to_ds_bus, 0);
        check("rst_drop", dut.drop_cnt_q, 0);
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [BW-1:0]      held;
        logic [EXC_NUM-1:0] e;
        logic               fl, bc, dsa, dok, pv;
        cur_id  = 0;
        next_id = 0;
        model_clear();
        do_reset();

        // Single fetch: response two cycles after the load.
        step(1'b1, 32'h1c000000, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b0, 32'h0, '0, 1'b1, 32'h02800421, 1'b1, 1'b0, 1'b0);
        check("sf_valid", last_valid, 1);
        check("sf_bus", last_bus, {15'h0, 32'h02800421, 32'h1c000000});
        idle(1'b1);
        check("sf_once", last_valid, 0);

        // Decode stall: buffered instruction held for three cycles.
        step(1'b1, 32'h1c000010, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, '0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
        check("st_valid", last_valid, 1);
        check("st_allowin", last_allowin, 0);
        held = last_bus;
        check("st_bus", held, {15'h0, 32'h12345678, 32'h1c000010});
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check("st_hold_bus", last_bus, {15'h0, 32'h12345678, 32'h1c000010});
            check("st_hold_allowin", last_allowin, 0);
        end
        idle(1'b1);
        check("st_release", last_valid, 1);
        check("st_release_bus", last_bus, {15'h0, 32'h12345678, 32'h1c000010});
        idle(1'b1);
        check("st_once", last_valid, 0);

        // Flush with the response in flight.
        step(1'b1, 32'h1c000004, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, '0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("fl_drop1", dut.drop_cnt_q, 1);
        step(1'b1, 32'h1c008000, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, '0, 1'b1, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0);
        check("fl_discard", last_valid, 0);
        check("fl_drop0", dut.drop_cnt_q, 0);
        step(1'b0, 32'h0, '0, 1'b1, 32'hBBBBBBBB, 1'b1, 1'b0, 1'b0);
        check("fl_deliver", last_valid, 1);
        check("fl_bus", last_bus, {15'h0, 32'hBBBBBBBB, 32'h1c008000});

        // Cancel in the same cycle as the response.
        step(1'b1, 32'h1c000020, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, '0, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b1);
        check("cc_valid", last_valid, 0);
        check("cc_drop", dut.drop_cnt_q, 0);
        idle(1'b1);
        check("cc_allowin", last_allowin, 1);

        // Exception entry: instruction forced to zero.
        step(1'b1, 32'h1c000002, ADEF_FLG, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, '0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        check("ex_valid", last_valid, 1);
        check("ex_bus", last_bus, {ADEF_FLG, 32'h0, 32'h1c000002});

        // Streaming: eight entries, one per cycle.
        step(1'b1, 32'h1c001000, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 32'h1c001000 + 32'(4 * i), '0, 1'b1, 32'h00100000 + 32'(i - 1), 1'b1, 1'b0, 1'b0);
            check("sm_valid", last_valid, 1);
            check("sm_pc", last_bus[31:0], 32'h1c001000 + 32'(4 * (i - 1)));
            check("sm_allowin", last_allowin, 1);
        end
        step(1'b0, 32'h0, '0, 1'b1, 32'h00100007, 1'b1, 1'b0, 1'b0);
        check("sm_last", last_bus, {15'h0, 32'h00100007, 32'h1c00101c});

        // Two stale responses outstanding.
        step(1'b1, 32'h1c002000, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, '0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h1c002004, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("d2_drop2", dut.drop_cnt_q, 2);
        step(1'b1, 32'h1c002008, '0, 1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0);
        check("d2_discard1", last_valid, 0);
        step(1'b0, 32'h0, '0, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0);
        check("d2_discard2", last_valid, 0);
        step(1'b0, 32'h0, '0, 1'b1, 32'h44444444, 1'b1, 1'b0, 1'b0);
        check("d2_bus", last_bus, {15'h0, 32'h44444444, 32'h1c002008});

        // Reset with a stale response pending.
        step(1'b1, 32'h1c003000, '0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, '0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("rm_drop1", dut.drop_cnt_q, 1);
        do_reset();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            fl  = ($urandom_range(0, 11) == 0) && (out_q.size() <= 2);
            bc  = ($urandom_range(0, 11) == 0) && (out_q.size() <= 2);
            dsa = ($urandom_range(0, 3) != 0);
            dok = (out_q.size() > 0) && ($urandom_range(0, 2) != 0);
            pv  = !(fl || bc) && m_allowin(dok, dsa) && ($urandom_range(0, 3) != 0);
            e   = '0;
            if ($urandom_range(0, 7) == 0) e[$urandom_range(0, EXC_NUM - 1)] = 1'b1;
            step(pv, $urandom & 32'hFFFF_FFFC, e, dok, $urandom, dsa, fl, bc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
